// File: rtl/alarm_qsys_button_pio.sv
// alarm_qsys_button_pio
// ---------------------------------------------------------------------------
// Avalon-MM slave input port for the alarm-clock push-buttons and switches.
// Each board input is passed through a 2-flop synchroniser and a debouncer
// into a `stable` level. Qualifying edges of the stable level are latched in a
// write-1-to-clear edge-capture register, and a maskable level interrupt is
// raised while any unmasked capture bit is set.
//
// Register map (address):
//   0 DATA    : read-only debounced level, zero-extended; writes ignored
//   1         : reads 0; writes ignored
//   2 IRQMASK : read/write, WIDTH bits
//   3 EDGECAP : read; writing 1 clears a bit, 0 leaves it (a new edge wins)
//
// Bus handshake: a write happens on any clock edge where
// chipselect && !write_n; there are no wait states. readdata is a pure
// combinational mux of registers selected by address (read latency 0).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register select (2 bits)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (bits above WIDTH ignored)
//   readdata   read data
//   in_port    asynchronous board inputs (WIDTH bits)
//   irq        level interrupt, active high
//
// Configuration macro: BUTTON_PIO_DEBOUNCE_EN
//   defined   : per-bit debounce counters requiring DEBOUNCE_CYCLES
//               consecutive clocks of a new level before it is accepted.
//   undefined : no counters; the stable level is the second synchroniser
//               flop and DEBOUNCE_CYCLES is unused.
// ---------------------------------------------------------------------------
module alarm_qsys_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_FALLING    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Idle level of the inputs: buttons are active-low when capturing falling
  // edges, so resetting the pipeline to all-ones avoids a spurious edge.
  localparam logic [WIDTH-1:0] RST_LVL = (EDGE_FALLING != 0) ? '1 : '0;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused;

  // Upper writedata bits are intentionally ignored.
  assign w_unused = ^writedata;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= RST_LVL;
      r_sync2 <= RST_LVL;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  // ---------------------------------------------------------------------
  // Debouncer: a bit's counter runs only while the synchronised level
  // disagrees with the stable level; any agreement (including a glitch
  // ending) snaps it back to 0, so only an uninterrupted run of
  // DEBOUNCE_CYCLES mismatching clocks updates `stable`.
  // ---------------------------------------------------------------------
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_stable <= RST_LVL;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_stable = r_stable;
`else
  assign w_stable = r_sync2;
`endif

  // ---------------------------------------------------------------------
  // Edge detection on the stable level
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= RST_LVL;
    end else begin
      r_prev <= w_stable;
    end
  end

  assign w_edge = (EDGE_FALLING != 0) ? (r_prev & ~w_stable)
                                      : (~r_prev & w_stable);

  // ---------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------
  assign w_wr  = chipselect && !write_n;
  assign w_clr = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqmask <= '0;
    end else if (w_wr && (address == 2'd2)) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  // The OR with w_edge after clearing makes a new edge win over a
  // simultaneous write-1-clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = w_stable;
      2'd2:    readdata[WIDTH-1:0] = r_irqmask;
      2'd3:    readdata[WIDTH-1:0] = r_edgecap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_alarm_qsys_button_pio.sv
// tb_alarm_qsys_button_pio
// Directed bench for alarm_qsys_button_pio. Main instance: WIDTH=4,
// DEBOUNCE_CYCLES=4, falling-edge capture. Second instance: rising-edge
// capture, always reading EDGECAP. Expected latencies follow the build
// configuration of the BUTTON_PIO_DEBOUNCE_EN macro.
module tb_alarm_qsys_button_pio;

  localparam int D = 4;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  // in_port sampled at edge k -> stable at edge k+1+D
  localparam int          DEB_LAT    = 1 + D;
  localparam logic [31:0] GLITCH_CAP = 32'h0;
`else
  localparam int          DEB_LAT    = 1;
  localparam logic [31:0] GLITCH_CAP = 32'h2;
`endif
  localparam int EDGE_LAT = DEB_LAT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  logic [1:0]  address_r;
  logic        chipselect_r;
  logic        write_n_r;
  logic [31:0] writedata_r;
  logic [31:0] readdata_r;
  logic [3:0]  in_port_r;
  logic        irq_r;

  alarm_qsys_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_FALLING(1)) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  alarm_qsys_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_FALLING(0)) u_dut_r (
    .clk(clk), .reset(reset), .address(address_r), .chipselect(chipselect_r),
    .write_n(write_n_r), .writedata(writedata_r), .readdata(readdata_r),
    .in_port(in_port_r), .irq(irq_r)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b1;
    address      = 2'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = 32'h0;
    in_port      = 4'hF;
    address_r    = 2'd3;
    chipselect_r = 1'b0;
    write_n_r    = 1'b1;
    writedata_r  = 32'h0;
    in_port_r    = 4'h0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    bus_read(2'd0, rd); check("rst_data", rd, 32'h0000000F);
    bus_read(2'd2, rd); check("rst_mask", rd, 32'h0);
    bus_read(2'd3, rd); check("rst_edgecap", rd, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_r_edgecap", readdata_r, 32'h0);

    // Glitch: bit 1 low for 3 clocks
    in_port = 4'hD;
    repeat (3) tick();
    in_port = 4'hF;
`ifdef BUTTON_PIO_DEBOUNCE_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      bus_read(2'd0, rd); check("glitch_data", rd, 32'h0000000F);
    end
`else
    repeat (8) tick();
    bus_read(2'd0, rd); check("glitch_data", rd, 32'h0000000F);
`endif
    bus_read(2'd3, rd); check("glitch_edgecap", rd, GLITCH_CAP);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd); check("glitch_clear", rd, 32'h0);

    // Clean press on bit 0 with IRQMASK=1
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); check("mask_rb", rd, 32'h1);
    in_port = 4'hE;
    for (int i = 0; i <= EDGE_LAT; i++) begin
      tick();  // now just after edge k+i
      bus_read(2'd0, rd);
      check("press_data", rd, (i >= DEB_LAT) ? 32'hE : 32'hF);
      bus_read(2'd3, rd);
      check("press_edgecap", rd, (i >= EDGE_LAT) ? 32'h1 : 32'h0);
      check("press_irq", {31'h0, irq}, (i >= EDGE_LAT) ? 32'h1 : 32'h0);
    end

    // Writes to DATA and address 1 are ignored
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, rd); check("data_ro", rd, 32'hE);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check("addr1_zero", rd, 32'h0);

    // Release bit 0 (rising edge: not captured in falling mode)
    in_port = 4'hF;
    repeat (EDGE_LAT + 2) tick();
    bus_read(2'd0, rd); check("release_data", rd, 32'hF);
    bus_read(2'd3, rd); check("release_edgecap", rd, 32'h1);

    // Collision: clear bit 0 on the very edge a new bit-0 edge latches
    in_port = 4'hE;
    repeat (DEB_LAT + 1) tick();   // through edge k+DEB_LAT
    bus_write(2'd3, 32'h1);        // edge k+EDGE_LAT
    bus_read(2'd3, rd); check("collide_edgecap", rd, 32'h1);
    check("collide_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd); check("clear_edgecap", rd, 32'h0);
    check("clear_irq", {31'h0, irq}, 32'h0);

    // Mask: press and release bit 2 with IRQMASK=0
    bus_write(2'd2, 32'h0);
    in_port = 4'hA;
    repeat (EDGE_LAT + 2) tick();
    in_port = 4'hE;
    repeat (EDGE_LAT + 2) tick();
    bus_read(2'd3, rd); check("mask_edgecap", rd, 32'h4);
    check("mask_irq_off", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h4);
    check("mask_irq_on", {31'h0, irq}, 32'h1);

    // Rising-edge instance: 0->1 on bit 3
    in_port_r = 4'h8;
    for (int i = 0; i <= EDGE_LAT; i++) begin
      tick();
      check("rise_edgecap", readdata_r, (i >= EDGE_LAT) ? 32'h8 : 32'h0);
    end
    writedata_r  = 32'h8;
    chipselect_r = 1'b1;
    write_n_r    = 1'b0;
    tick();
    chipselect_r = 1'b0;
    write_n_r    = 1'b1;
    check("rise_clear", readdata_r, 32'h0);
    in_port_r = 4'h0;
    repeat (EDGE_LAT + 3) tick();
    check("fall_ignored", readdata_r, 32'h0);
    check("fall_irq_r", {31'h0, irq_r}, 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
